// File: rtl/reg_bank_pkg.sv
// Shared defaults and address/data typedefs for the scoreboarded register bank.
package reg_bank_pkg;
  localparam int REG_WIDTH_DEF = 16;
  localparam int REG_DEPTH_DEF = 8;
  localparam int REG_AW_DEF    = $clog2(REG_DEPTH_DEF);

  typedef logic [REG_AW_DEF-1:0]    reg_addr_t;
  typedef logic [REG_WIDTH_DEF-1:0] reg_data_t;
endpackage

// File: rtl/reg_bank_rd_port.sv
// One combinational read port: array/busy mux, zero-register masking and,
// when REG_BANK_SB_BYPASS_EN is defined, write-first forwarding.
module reg_bank_rd_port
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH_DEF,
  parameter int DEPTH    = REG_DEPTH_DEF,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]            busy,
  input  logic [AW-1:0]               r_reg,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_reg,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rsv_en,
  input  logic [AW-1:0]               rsv_reg,
  output logic [WIDTH-1:0]            r_data,
  output logic                        r_busy
);
  logic is_zero;
  assign is_zero = (ZERO_REG != 0) && (r_reg == '0);

`ifndef REG_BANK_SB_BYPASS_EN
  logic bypass_unused;
  assign bypass_unused = ^{wr_en, wr_reg, wr_data, rsv_en, rsv_reg};
`endif

  always_comb begin
    r_data = mem[r_reg];
    r_busy = busy[r_reg];
`ifdef REG_BANK_SB_BYPASS_EN
    // A same-edge reserve means a newer producer is already in flight.
    if (wr_en && (r_reg == wr_reg)) begin
      r_data = wr_data;
      r_busy = rsv_en && (rsv_reg == wr_reg);
    end
`endif
    if (is_zero) begin
      r_data = '0;
      r_busy = 1'b0;
    end
  end
endmodule

// File: rtl/reg_bank_sb.sv
// Register bank with two async read ports, one write port and a busy scoreboard.
// Optional write-first read forwarding: define REG_BANK_SB_BYPASS_EN.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH_DEF,
  parameter int DEPTH    = REG_DEPTH_DEF,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_reg,
  input  logic [AW-1:0]    r_reg1,
  input  logic [AW-1:0]    r_reg2,
  output logic [WIDTH-1:0] r_data1,
  output logic [WIDTH-1:0] r_data2,
  output logic             r_busy1,
  output logic             r_busy2,
  output logic             any_busy
);
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic                        wr_ok, rsv_ok;

  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_reg  == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_reg == '0));

  // Reserve is applied after the write so a same-register issue stays busy.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_ok) begin
      mem_d[wr_reg]  = wr_data;
      busy_d[wr_reg] = 1'b0;
    end
    if (rsv_ok) busy_d[rsv_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign any_busy = |busy_q;

  logic [NUM_RD-1:0][AW-1:0]    rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;

  assign rd_addr = {r_reg2, r_reg1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_bank_rd_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .mem    (mem_q),
      .busy   (busy_q),
      .r_reg  (rd_addr[p]),
      .wr_en  (wr_en),
      .wr_reg (wr_reg),
      .wr_data(wr_data),
      .rsv_en (rsv_en),
      .rsv_reg(rsv_reg),
      .r_data (rd_data[p]),
      .r_busy (rd_busy[p])
    );
  end

  assign r_data1 = rd_data[0];
  assign r_data2 = rd_data[1];
  assign r_busy1 = rd_busy[0];
  assign r_busy2 = rd_busy[1];
endmodule

// File: tb/tb_reg_bank_sb.sv
// Bench for reg_bank_sb: two instances (ZERO_REG=0 and 1) driven in lockstep,
// checked against a table of directed vectors and an array-based reference model.
module tb_reg_bank_sb;
  import reg_bank_pkg::*;

  logic clk, rst;
  logic wr_en, rsv_en;
  reg_addr_t wr_reg, rsv_reg, r1, r2;
  reg_data_t wr_data;
  logic [1:0][15:0] rd1, rd2;
  logic [1:0]       rb1, rb2, anyb;

  int n_chk = 0;
  int n_fail = 0;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    reg_bank_sb #(.WIDTH(16), .DEPTH(8), .ZERO_REG(d)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_reg(rsv_reg), .r_reg1(r1), .r_reg2(r2),
      .r_data1(rd1[d]), .r_data2(rd2[d]), .r_busy1(rb1[d]), .r_busy2(rb2[d]),
      .any_busy(anyb[d])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arrays of stored values and busy flags per instance.
  logic [15:0] m_mem  [2][8];
  logic        m_busy [2][8];

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        for (int k = 0; k < 8; k++) begin
          m_mem[d][k] = 16'h0;
          m_busy[d][k] = 1'b0;
        end
      end else begin
        if (wr_en && !(d == 1 && wr_reg == 0)) begin
          m_mem[d][wr_reg] = wr_data;
          m_busy[d][wr_reg] = 1'b0;
        end
        if (rsv_en && !(d == 1 && rsv_reg == 0)) m_busy[d][rsv_reg] = 1'b1;
      end
    end
  endtask

  function automatic logic [16:0] m_read(int d, reg_addr_t r);
    logic [15:0] data;
    logic        b;
    data = m_mem[d][r];
    b = m_busy[d][r];
`ifdef REG_BANK_SB_BYPASS_EN
    if (wr_en && r == wr_reg) begin
      data = wr_data;
      b = rsv_en && (rsv_reg == wr_reg);
    end
`endif
    if (d == 1 && r == 0) begin
      data = 16'h0;
      b = 1'b0;
    end
    return {b, data};
  endfunction

  function automatic logic m_any(int d);
    logic a = 1'b0;
    for (int k = 0; k < 8; k++) a |= m_busy[d][k];
    return a;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; rst = 1'b1;
  endtask

  // Compare both instances against the model for the currently applied inputs.
  task automatic check_model(string tag, int dmin);
    logic [16:0] e1, e2;
    #1;
    for (int d = dmin; d < 2; d++) begin
      e1 = m_read(d, r1);
      e2 = m_read(d, r2);
      chk($sformatf("%s d%0d rd1", tag, d), 32'(rd1[d]), 32'(e1[15:0]));
      chk($sformatf("%s d%0d rd2", tag, d), 32'(rd2[d]), 32'(e2[15:0]));
      chk($sformatf("%s d%0d rb1", tag, d), 32'(rb1[d]), 32'(e1[16]));
      chk($sformatf("%s d%0d rb2", tag, d), 32'(rb2[d]), 32'(e2[16]));
      chk($sformatf("%s d%0d any", tag, d), 32'(anyb[d]), 32'(m_any(d)));
    end
  endtask

  typedef struct {
    logic        wr_en;
    reg_addr_t   wr_reg;
    reg_data_t   wr_data;
    logic        rsv_en;
    reg_addr_t   rsv_reg;
    reg_addr_t   r1, r2;
    reg_data_t   d1, d2;
    logic        b1, b2, any;
  } vec_t;

  function automatic vec_t mk(logic we, int wreg, int wdat, logic re, int rreg,
                              int a1, int a2, int d1, int d2, logic b1, logic b2, logic any);
    vec_t v;
    v.wr_en = we; v.wr_reg = reg_addr_t'(wreg); v.wr_data = reg_data_t'(wdat);
    v.rsv_en = re; v.rsv_reg = reg_addr_t'(rreg);
    v.r1 = reg_addr_t'(a1); v.r2 = reg_addr_t'(a2);
    v.d1 = reg_data_t'(d1); v.d2 = reg_data_t'(d2);
    v.b1 = b1; v.b2 = b2; v.any = any;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    // Expected values are for the ZERO_REG=0 instance, read after the edge.
    for (int i = 0; i < 8; i++) vt.push_back(mk(1, i, (i+1)*4, 0, 0, i, i, (i+1)*4, (i+1)*4, 0, 0, 0));
    for (int i = 0; i < 8; i++) vt.push_back(mk(0, 0, 0, 0, 0, i, 7-i, (i+1)*4, (8-i)*4, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,      1, 5, 5, 0, 24,     4,      1, 0, 1));
    vt.push_back(mk(1, 5, 'hAB,   0, 0, 5, 5, 'hAB,   'hAB,   0, 0, 0));
    vt.push_back(mk(1, 2, 'h1234, 1, 2, 2, 3, 'h1234, 16,     1, 0, 1));
    vt.push_back(mk(1, 2, 'h55,   0, 0, 2, 2, 'h55,   'h55,   0, 0, 0));
    vt.push_back(mk(1, 6, 'h66,   1, 3, 3, 6, 16,     'h66,   1, 0, 1));
    vt.push_back(mk(0, 0, 0,      1, 3, 3, 3, 16,     16,     1, 1, 1));
    vt.push_back(mk(1, 3, 'h77,   0, 0, 3, 3, 'h77,   'h77,   0, 0, 0));
    vt.push_back(mk(1, 7, 'hEE,   0, 0, 7, 0, 'hEE,   4,      0, 0, 0));
    vt.push_back(mk(0, 0, 0,      1, 0, 0, 7, 4,      'hEE,   1, 0, 1));
    vt.push_back(mk(1, 0, 'h99,   0, 0, 0, 0, 'h99,   'h99,   0, 0, 0));

    idle();
    wr_reg = 0; wr_data = 0; rsv_reg = 0; r1 = 0; r2 = 0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) begin m_mem[d][k] = 16'hx; m_busy[d][k] = 1'bx; end

    // Reset, with a write and reserve presented that must be overridden.
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b1; wr_reg = 3; wr_data = 16'hFFFF; rsv_en = 1'b1; rsv_reg = 4;
    tick();
    tick();
    idle();
    for (int r = 0; r < 8; r++) begin
      r1 = reg_addr_t'(r); r2 = reg_addr_t'(7 - r);
      #1;
      chk($sformatf("reset rd1 r%0d", r), 32'(rd1[0]), 32'h0);
      chk($sformatf("reset rb1 r%0d", r), 32'(rb1[0]), 32'h0);
      chk($sformatf("reset any r%0d", r), 32'(anyb[0]), 32'h0);
      check_model("reset", 1);
    end

    // Write 0xFFFF to reg 3, then a single reset edge must clear it.
    wr_en = 1'b1; wr_reg = 3; wr_data = 16'hFFFF;
    tick();
    idle(); r1 = 3; #1;
    chk("prereset rd1", 32'(rd1[0]), 32'hFFFF);
    rst = 1'b0;
    tick();
    idle();
    for (int r = 0; r < 8; r++) begin
      r1 = reg_addr_t'(r); #1;
      chk($sformatf("reset2 rd1 r%0d", r), 32'(rd1[0]), 32'h0);
      chk($sformatf("reset2 any r%0d", r), 32'(anyb[0]), 32'h0);
    end

    // Directed table.
    foreach (vt[i]) begin
      wr_en = vt[i].wr_en; wr_reg = vt[i].wr_reg; wr_data = vt[i].wr_data;
      rsv_en = vt[i].rsv_en; rsv_reg = vt[i].rsv_reg;
      tick();
      idle();
      r1 = vt[i].r1; r2 = vt[i].r2;
      #1;
      chk($sformatf("vec%0d rd1", i), 32'(rd1[0]), 32'(vt[i].d1));
      chk($sformatf("vec%0d rd2", i), 32'(rd2[0]), 32'(vt[i].d2));
      chk($sformatf("vec%0d rb1", i), 32'(rb1[0]), 32'(vt[i].b1));
      chk($sformatf("vec%0d rb2", i), 32'(rb2[0]), 32'(vt[i].b2));
      chk($sformatf("vec%0d any", i), 32'(anyb[0]), 32'(vt[i].any));
      check_model($sformatf("vec%0d", i), 1);
    end

    // Same-cycle read of the register being written.
    wr_en = 1'b1; wr_reg = 4; wr_data = 16'h0010;
    tick();
    wr_en = 1'b1; wr_reg = 4; wr_data = 16'hBEEF; r1 = 4; r2 = 4;
    #1;
`ifdef REG_BANK_SB_BYPASS_EN
    chk("samecyc rd1", 32'(rd1[0]), 32'hBEEF);
`else
    chk("samecyc rd1", 32'(rd1[0]), 32'h0010);
`endif
    chk("samecyc rb1", 32'(rb1[0]), 32'h0);
    tick();
    idle();
    #1;
    chk("postedge rd1", 32'(rd1[0]), 32'hBEEF);

    // Reset mid-operation discards reservations; a later write still lands.
    rsv_en = 1'b1;
    rsv_reg = 1; tick();
    rsv_reg = 2; tick();
    rsv_reg = 6; tick();
    idle(); r1 = 6; r2 = 1; #1;
    chk("midrst busy6", 32'(rb1[0]), 32'h1);
    chk("midrst busy1", 32'(rb2[0]), 32'h1);
    rst = 1'b0;
    tick();
    idle(); #1;
    chk("midrst any", 32'(anyb[0]), 32'h0);
    chk("midrst rb1", 32'(rb1[0]), 32'h0);
    wr_en = 1'b1; wr_reg = 6; wr_data = 16'h0042;
    tick();
    idle(); r1 = 6; #1;
    chk("midrst rd1", 32'(rd1[0]), 32'h0042);
    chk("midrst rb1b", 32'(rb1[0]), 32'h0);
    check_model("midrst", 0);

    // Randomized traffic against the model, checked before and after each edge.
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 39) != 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_reg  = reg_addr_t'($urandom_range(0, 7));
      wr_data = reg_data_t'($urandom);
      rsv_en  = 1'($urandom_range(0, 1));
      rsv_reg = ($urandom_range(0, 3) == 0) ? wr_reg : reg_addr_t'($urandom_range(0, 7));
      r1      = ($urandom_range(0, 2) == 0) ? wr_reg : reg_addr_t'($urandom_range(0, 7));
      r2      = reg_addr_t'($urandom_range(0, 7));
      check_model("rnd", 0);
      tick();
    end
    idle();
    check_model("final", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised register bank with two asynchronous read ports, one synchronous write port and a per-register busy scoreboard. It generalises the fixed 16-bit, 8-entry bank to arbitrary width and depth. It also adds an optional hardwired-zero register and reservation tracking, so the issue stage can detect read-after-write hazards against in-flight producers. It sits between decode/issue (reads, reservations) and writeback (writes) in the datapath.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers; power of two, ≥2
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and reservations
- AW (localparam), $clog2(DEPTH), register address width
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- wr_en  in  1  write enable
- wr_reg  in  AW  write address
- wr_data  in  WIDTH  write data
- rsv_en  in  1  reserve request: mark rsv_reg busy (producer issued)
- rsv_reg  in  AW  register to reserve
- r_reg1, r_reg2  in  AW  read addresses
- r_data1, r_data2  out  WIDTH  read data
- r_busy1, r_busy2  out  1  busy flag of the addressed register
- any_busy  out  1  OR of all busy bits

## Operation
- Storage: DEPTH × WIDTH registers plus a DEPTH-bit busy vector.
- Reset (rst=0 at a rising edge): all registers cleared to 0 and all busy bits cleared.
  - Outputs then read r_data=0, r_busy=0, any_busy=0.
  - Reset overrides wr_en and rsv_en in the same cycle.
- Write: wr_en=1 at the edge stores wr_data into wr_reg and clears busy[wr_reg].
- Reserve: rsv_en=1 at the edge sets busy[rsv_reg].
  - Reserving an already-busy register leaves it busy. There is a single bit, not a count.
- Simultaneous write and reserve to the same register: data is written and busy ends at 1, because the new producer wins.
- Simultaneous write and reserve to different registers: both take effect.
- ZERO_REG=1:
  - Writes and reservations to register 0 are dropped.
  - r_dataN=0 and r_busyN=0 whenever r_regN=0.
- Reads are combinational from r_regN. Both ports may address the same register, including wr_reg.
- Writing a register that is not busy is legal: data is stored and busy stays 0.

## Timing
- Write latency: data is visible on a read port the cycle after the write edge (unless bypass is enabled; see Configuration).
- Busy set/clear is visible on r_busyN and any_busy the cycle after the edge.
- Read path is purely combinational, with zero cycles from r_reg to r_data/r_busy.
- No handshake and no backpressure: every write and reserve is accepted in the cycle presented.
- Reset mid-operation discards pending reservations. Any in-flight producer's later write still lands normally.

## Configuration
- REG_BANK_SB_BYPASS_EN defined: write-first forwarding.
  - If wr_en=1 and r_regN==wr_reg (and not register 0 when ZERO_REG=1), then r_dataN=wr_data in the same cycle.
  - r_busyN=0 in that case unless rsv_en=1 with rsv_reg==wr_reg in the same cycle, in which case r_busyN=1.
- Not defined: read ports always return stored state. A same-cycle read returns the old value and old busy bit.
- The macro has no effect on stored state, only on the read outputs.

## Structure
- Shared package `reg_bank_pkg`:
  - default WIDTH/DEPTH constants
  - `reg_addr_t` / `reg_data_t` typedefs derived from them
- One sub-module, `reg_bank_rd_port`:
  - instantiated twice
  - performs the array/busy mux, zero-register masking and the optional bypass compare
- The top level holds the storage array, busy vector and write/reserve logic.

## Test plan
- Reset: hold rst=0 for one edge after writing 0xFFFF to reg 3 → r_data=0x0000 and any_busy=0 on all addresses.
- Sequential fill (WIDTH=16, DEPTH=8): write (i+1)*4 to reg i for i=0..7, then read pairs (i, 7−i).
  - Expected r_data1=(i+1)*4 and r_data2=(8−i)*4.
  - With ZERO_REG=1, reg 0 reads 0x0000.
- Scoreboard: reserve reg 5 → next cycle r_busy1=1 (r_reg1=5) and any_busy=1; write 0x00AB to reg 5 → next cycle r_busy1=0, r_data1=0x00AB, any_busy=0.
- Same-cycle write and reserve on reg 2 with data 0x1234 → next cycle r_data=0x1234, r_busy=1.
- Same-cycle read of wr_reg=4, wr_data=0xBEEF, old value 0x0010:
  - With REG_BANK_SB_BYPASS_EN, r_data1=0xBEEF in the same cycle.
  - Without it, r_data1=0x0010, then 0xBEEF after the edge.
- Reset mid-operation: reserve regs 1, 2 and 6, then rst=0 → all busy bits clear. A subsequent write of 0x0042 to reg 6 reads back 0x0042 with busy=0.
